csdf_np_nf_pick: RTL and testbench
==================================

Name: csdf_np_nf_pick

Overview:
- Parametrised N-flow pick-accumulator for the CSDF actor library.
- Has NFLOW input FIFO channels and one shared output FIFO.
- Each flow accumulates ACC_LEN tokens independently, then emits one tagged token {flow_id, sum}.
- Selection uses a fair round-robin arbiter instead of fixed two-flow priority. Wrap or saturating accumulation is chosen by parameter.

Parameters:
- WIDTH, 8, output token width; accumulator width AW = WIDTH - TAGW.
- NFLOW, 2, number of input flows (>= 2).
- ACC_LEN, 4, tokens summed per output token (>= 2).
- SAT, 0, 0 = accumulate modulo 2^AW; 1 = clamp at 2^AW - 1.
- TAGW (localparam), clog2(NFLOW), flow-id tag width.

Ports:
- ck  input  1  clock; all state on rising edge.
- rst  input  1  asynchronous, active-low reset.
- in_data  input  NFLOW*WIDTH  flattened input tokens; flow i occupies bits [i*WIDTH +: WIDTH]; only the low AW bits are used.
- in_empty  input  NFLOW  per-flow FIFO empty.
- in_read  output  NFLOW  per-flow FIFO read strobe; at most one bit high.
- full  input  1  output FIFO full.
- wr  output  1  output FIFO write strobe.
- out_data  output  WIDTH  {tag[TAGW-1:0], acc[AW-1:0]}.

Behaviour:
- Reset: while rst = 0, and asynchronously on its falling edge, the following are forced and held.
  - Per-flow acc = 0, cnt = 0, ready = 0; rr_ptr = 0.
  - in_read = 0, wr = 0, out_data = 0, gated combinationally.
- Per-flow state: acc[AW], cnt in 0..ACC_LEN-1, ready flag.
- Eligibility (combinational): elig_i = (ready_i & ~full) | (~ready_i & ~in_empty_i).
- Arbitration: grant g = first eligible flow searching rr_ptr, rr_ptr+1, ... modulo NFLOW.
  - At most one flow is served per cycle.
  - If no flow is eligible: in_read = 0, wr = 0, out_data = 0, no state change, rr_ptr unchanged.
- Emit (ready_g = 1, full = 0), all combinational in the same cycle:
  - wr = 1, out_data = {g, acc_g}, in_read = 0.
  - Next edge: acc_g = 0, ready_g = 0, cnt_g = 0.
- Read (ready_g = 0, in_empty_g = 0), combinational in the same cycle:
  - in_read[g] = 1, wr = 0, out_data = {g, acc_g}.
  - Next edge: acc_g = acc_g + in_data_g[AW-1:0], wrapped (SAT = 0) or clamped (SAT = 1).
  - If cnt_g == ACC_LEN-1: ready_g = 1 and cnt_g = 0; otherwise cnt_g + 1.
- Pointer: after any served cycle, rr_ptr = (g + 1) mod NFLOW on the next edge.
- Latency:
  - The earliest emission is the cycle after the ACC_LEN-th read of a flow.
  - Continuous single flow: one output every ACC_LEN+1 cycles.
- Backpressure: a ready flow holds its acc while full = 1 and reads no further tokens. Other flows remain eligible to read.
- Independence: a flow's state changes only in cycles where it holds the grant.
- Simultaneous emit-eligible and read-eligible flows: neither type has priority; round-robin order alone decides.
- in_data of a non-granted flow is ignored.
- X-free: no output depends on in_data of a flow whose empty = 1.

Test Plan:
1. NFLOW=3, WIDTH=8 (AW=6), ACC_LEN=4; hold rst=0 with in_empty=000, full=0, then release -> in_read=000, wr=0, out_data=0 throughout; first grant goes to flow 0.
2. Flow 0 supplies 1,2,3,4 back-to-back, others empty -> in_read[0]=1 for 4 cycles; 5th cycle wr=1, out_data=8'h0A ({2'd0,6'd10}); 6th cycle acc0 restarts from 0.
3. All three flows non-empty with constant data 1 -> grant sequence 0,1,2,0,1,2,...; after 12 reads, emissions 8'h04, 8'h44, 8'h84 in flow order, interleaved round-robin.
4. Flow 1 ready with acc=7, full=1 for 5 cycles, flow 2 streaming -> wr=0, in_read[1]=0, flow 2 reads continue; full drops -> wr=1, out_data=8'h47.
5. Flow 0 supplies 63,63,63,63 -> SAT=0 emits 8'h3C (252 mod 64 = 60); SAT=1 emits 8'h3F.
6. After 2 reads on flow 0, pulse rst low mid-cycle -> outputs drop to 0 immediately; after release, 4 fresh tokens 1,1,1,1 give out_data=8'h04, not 8'h06.

Source files
------------

// File: rtl/csdf_np_nf_pick_if.sv
// Handshake bundle for the N-flow pick-accumulator: NFLOW input FIFO channels
// plus one shared output FIFO write port.
interface csdf_np_nf_pick_if #(
    parameter int WIDTH = 8,
    parameter int NFLOW = 2
);
    logic [NFLOW*WIDTH-1:0] in_data;
    logic [NFLOW-1:0]       in_empty;
    logic [NFLOW-1:0]       in_read;
    logic                   full;
    logic                   wr;
    logic [WIDTH-1:0]       out_data;

    // master drives the FIFO status and data; slave is the actor itself
    modport master (
        output in_data, in_empty, full,
        input  in_read, wr, out_data
    );
    modport slave (
        input  in_data, in_empty, full,
        output in_read, wr, out_data
    );
endinterface

// File: rtl/csdf_np_nf_pick.sv
// N-flow pick-accumulator: each flow sums ACC_LEN tokens, then emits one
// {flow_id, sum} token; a round-robin arbiter serves one flow per cycle.
module csdf_np_nf_pick #(
    parameter int WIDTH   = 8,
    parameter int NFLOW   = 2,
    parameter int ACC_LEN = 4,
    parameter int SAT     = 0
) (
    input  logic              ck,
    input  logic              rst,
    csdf_np_nf_pick_if.slave  bus
);
    localparam int TAGW = $clog2(NFLOW);
    localparam int AW   = WIDTH - TAGW;
    localparam int CW   = $clog2(ACC_LEN);

    logic [AW-1:0]    acc_q [NFLOW];
    logic [AW-1:0]    acc_d [NFLOW];
    logic [CW-1:0]    cnt_q [NFLOW];
    logic [CW-1:0]    cnt_d [NFLOW];
    logic [NFLOW-1:0] ready_q, ready_d;
    logic [TAGW-1:0]  rr_q, rr_d;

    logic [NFLOW-1:0] elig;
    logic [AW-1:0]    acc_add [NFLOW];
    logic             any_gnt;
    logic [TAGW-1:0]  gnt_idx;
    logic             emit;
    logic             rd;

    genvar gi;
    generate
        for (gi = 0; gi < NFLOW; gi++) begin : g_flow
            logic [AW:0] raw_sum;
            logic        unused_tag_bits;

            assign elig[gi] = (ready_q[gi] & ~bus.full) | (~ready_q[gi] & ~bus.in_empty[gi]);
            assign raw_sum  = {1'b0, acc_q[gi]} + {1'b0, bus.in_data[gi*WIDTH +: AW]};
            // carry out of the AW-bit sum is the overflow that SAT clamps away
            assign acc_add[gi] = (SAT != 0 && raw_sum[AW]) ? {AW{1'b1}} : raw_sum[AW-1:0];
            assign unused_tag_bits = ^bus.in_data[gi*WIDTH+AW +: TAGW];
        end
    endgenerate

    // first eligible flow starting at rr_q, wrapping modulo NFLOW
    always_comb begin
        int idx;
        idx     = 0;
        any_gnt = 1'b0;
        gnt_idx = '0;
        for (int k = 0; k < NFLOW; k++) begin
            idx = (int'(rr_q) + k) % NFLOW;
            if (!any_gnt && elig[idx]) begin
                any_gnt = 1'b1;
                gnt_idx = TAGW'(idx);
            end
        end
    end

    assign emit = any_gnt &  ready_q[gnt_idx];
    assign rd   = any_gnt & ~ready_q[gnt_idx];

    always_comb begin
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ready_d = ready_q;
        rr_d    = rr_q;
        if (any_gnt) begin
            rr_d = (gnt_idx == TAGW'(NFLOW - 1)) ? '0 : gnt_idx + TAGW'(1);
            if (emit) begin
                acc_d[gnt_idx]   = '0;
                cnt_d[gnt_idx]   = '0;
                ready_d[gnt_idx] = 1'b0;
            end else begin
                acc_d[gnt_idx] = acc_add[gnt_idx];
                if (cnt_q[gnt_idx] == CW'(ACC_LEN - 1)) begin
                    cnt_d[gnt_idx]   = '0;
                    ready_d[gnt_idx] = 1'b1;
                end else begin
                    cnt_d[gnt_idx] = cnt_q[gnt_idx] + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge ck or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NFLOW; i++) begin
                acc_q[i] <= '0;
                cnt_q[i] <= '0;
            end
            ready_q <= '0;
            rr_q    <= '0;
        end else begin
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
            rr_q    <= rr_d;
        end
    end

    // outputs are gated by rst so they drop the instant reset asserts
    always_comb begin
        bus.wr       = rst & emit;
        bus.in_read  = (rst & rd) ? (NFLOW'(1) << gnt_idx) : '0;
        bus.out_data = (rst & any_gnt) ? {gnt_idx, acc_q[gnt_idx]} : '0;
    end
endmodule

// File: tb/tb_csdf_np_nf_pick.sv
// Bench for csdf_np_nf_pick: a wrap and a saturating instance share stimulus
// and are checked each cycle against a token-list model of each flow.
module tb_csdf_np_nf_pick;
    localparam int W  = 8;
    localparam int NF = 3;
    localparam int AL = 4;

    logic ck;
    logic rst;
    logic full;

    csdf_np_nf_pick_if #(.WIDTH(W), .NFLOW(NF)) bus0 ();
    csdf_np_nf_pick_if #(.WIDTH(W), .NFLOW(NF)) bus1 ();

    csdf_np_nf_pick #(.WIDTH(W), .NFLOW(NF), .ACC_LEN(AL), .SAT(0)) dut0 (
        .ck(ck), .rst(rst), .bus(bus0));
    csdf_np_nf_pick #(.WIDTH(W), .NFLOW(NF), .ACC_LEN(AL), .SAT(1)) dut1 (
        .ck(ck), .rst(rst), .bus(bus1));

    int errors = 0;
    int checks = 0;

    int fifo [NF][$];
    int toks [NF][$];
    bit pend [NF];
    int rr;
    logic [7:0] log0 [$];
    logic [7:0] log1 [$];
    logic [2:0] last_rd0;

    initial ck = 1'b0;
    always #5 ck = ~ck;

    task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    // sum of tokens collected so far, folded with wrap or clamp at 63
    function automatic int model_sum(int f, bit sat);
        int s;
        s = 0;
        for (int i = 0; i < toks[f].size(); i++) begin
            s = s + toks[f][i];
            if (sat) s = (s > 63) ? 63 : s;
            else     s = s % 64;
        end
        return s;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NF; i++) begin
            toks[i].delete();
            pend[i] = 1'b0;
        end
        rr = 0;
    endtask

    task automatic drive();
        for (int i = 0; i < NF; i++) begin
            logic [7:0] d;
            logic       e;
            e = (fifo[i].size() == 0);
            d = e ? 8'hFF : 8'(fifo[i][0]);
            bus0.in_data[i*W +: W] = d;
            bus1.in_data[i*W +: W] = d;
            bus0.in_empty[i] = e;
            bus1.in_empty[i] = e;
        end
        bus0.full = full;
        bus1.full = full;
    endtask

    task automatic push(int f, int v, int n);
        for (int i = 0; i < n; i++) fifo[f].push_back(v);
    endtask

    // one clock: check at negedge, advance model after posedge
    task automatic cycle();
        int g, kind, idx, s0, s1;
        logic [7:0] e0, e1;
        logic [2:0] erd;
        @(negedge ck);
        g = 0;
        kind = 0;
        if (rst) begin
            for (int k = 0; k < NF; k++) begin
                idx = (rr + k) % NF;
                if (kind == 0) begin
                    if (pend[idx] && !full) begin
                        kind = 2; g = idx;
                    end else if (!pend[idx] && fifo[idx].size() > 0) begin
                        kind = 1; g = idx;
                    end
                end
            end
        end
        s0  = model_sum(g, 1'b0);
        s1  = model_sum(g, 1'b1);
        erd = (kind == 1) ? 3'(1 << g) : 3'b000;
        e0  = (kind != 0) ? {2'(g), 6'(s0)} : 8'h00;
        e1  = (kind != 0) ? {2'(g), 6'(s1)} : 8'h00;
        chk("wr_sat0",   32'(bus0.wr),       32'(kind == 2));
        chk("read_sat0", 32'(bus0.in_read),  32'(erd));
        chk("data_sat0", 32'(bus0.out_data), 32'(e0));
        chk("wr_sat1",   32'(bus1.wr),       32'(kind == 2));
        chk("read_sat1", 32'(bus1.in_read),  32'(erd));
        chk("data_sat1", 32'(bus1.out_data), 32'(e1));
        last_rd0 = bus0.in_read;
        if (bus0.wr) begin
            log0.push_back(bus0.out_data);
            $display("t=%0t emit sat0 data=%02h", $time, bus0.out_data);
        end
        if (bus1.wr) begin
            log1.push_back(bus1.out_data);
            $display("t=%0t emit sat1 data=%02h", $time, bus1.out_data);
        end
        @(posedge ck);
        #1;
        if (!rst) begin
            model_reset();
        end else if (kind == 1) begin
            toks[g].push_back(fifo[g].pop_front());
            if (toks[g].size() == AL) pend[g] = 1'b1;
            rr = (g + 1) % NF;
        end else if (kind == 2) begin
            toks[g].delete();
            pend[g] = 1'b0;
            rr = (g + 1) % NF;
        end
        drive();
    endtask

    task automatic run(int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        rst  = 1'b0;
        full = 1'b0;
        model_reset();
        for (int f = 0; f < NF; f++) push(f, 1, AL);
        drive();
        @(posedge ck);
        #1;
        run(3);

        // all flows loaded with 1s: round-robin from flow 0
        rst = 1'b1;
        drive();
        log0.delete(); log1.delete();
        run(1);
        chk("first_grant", 32'(last_rd0), 32'h1);
        run(15);
        chk("rr_emit_count", log0.size(), 3);
        chk("rr_emit_0", 32'(log0[0]), 32'h04);
        chk("rr_emit_1", 32'(log0[1]), 32'h44);
        chk("rr_emit_2", 32'(log0[2]), 32'h84);

        // single flow 1,2,3,4
        log0.delete(); log1.delete();
        push(0, 1, 1); push(0, 2, 1); push(0, 3, 1); push(0, 4, 1);
        drive();
        run(6);
        chk("single_count", log0.size(), 1);
        chk("single_data", 32'(log0[0]), 32'h0A);

        // backpressure: flow 1 fills to 7 while full, flow 2 keeps reading
        log0.delete(); log1.delete();
        full = 1'b1;
        push(1, 1, 1); push(1, 2, 3);
        push(2, 1, 3);
        drive();
        run(8);
        chk("full_no_emit", log0.size(), 0);
        full = 1'b0;
        drive();
        run(3);
        chk("bp_count", log0.size(), 1);
        chk("bp_data", 32'(log0[0]), 32'h47);

        // overflow: wrap vs saturate
        log0.delete(); log1.delete();
        push(0, 63, 4);
        drive();
        run(6);
        chk("wrap_data", 32'(log0[0]), 32'h3C);
        chk("sat_data", 32'(log1[0]), 32'h3F);

        // mid-cycle asynchronous reset after two reads
        log0.delete(); log1.delete();
        push(0, 1, 2); push(0, 9, 2);
        drive();
        run(2);
        #2;
        chk("pre_rst_read", 32'(bus0.in_read), 32'h1);
        rst = 1'b0;
        #1;
        chk("async_rst_read0", 32'(bus0.in_read), 32'h0);
        chk("async_rst_wr0",   32'(bus0.wr),      32'h0);
        chk("async_rst_data0", 32'(bus0.out_data), 32'h0);
        chk("async_rst_read1", 32'(bus1.in_read), 32'h0);
        model_reset();
        for (int f = 0; f < NF; f++) fifo[f].delete();
        drive();
        run(2);
        rst = 1'b1;
        push(0, 1, 4);
        drive();
        run(6);
        chk("post_rst_count", log0.size(), 1);
        chk("post_rst_data0", 32'(log0[0]), 32'h04);
        chk("post_rst_data1", 32'(log1[0]), 32'h04);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
